// File: rtl/lc_pkg.sv
// Shared state encodings for the level-crossing gate controller and its bench.
package lc_pkg;

    localparam int LC_STATE_W = 3;

    localparam logic [LC_STATE_W-1:0] LC_OPEN     = 3'd0;
    localparam logic [LC_STATE_W-1:0] LC_WARN     = 3'd1;
    localparam logic [LC_STATE_W-1:0] LC_LOWERING = 3'd2;
    localparam logic [LC_STATE_W-1:0] LC_CLOSED   = 3'd3;
    localparam logic [LC_STATE_W-1:0] LC_RAISING  = 3'd4;
    localparam logic [LC_STATE_W-1:0] LC_FAULT    = 3'd5;

endpackage

// File: rtl/level_crossing_gate_ctrl_if.sv
// Road-side signal bundle: detection request and boom sensors in, lamp/buzzer/motor/fault out.
// There is no handshake: every signal is a level, sampled on each rising clock edge.
interface level_crossing_gate_ctrl_if;
    import lc_pkg::*;

    logic                  gate_open;
    logic                  limit_up;
    logic                  limit_down;
    logic                  obstruct;
    logic                  lamp;
    logic                  buzzer;
    logic                  motor_up;
    logic                  motor_down;
    logic                  gate_fault;
    logic [LC_STATE_W-1:0] state;

    modport master (
        output gate_open, limit_up, limit_down, obstruct,
        input  lamp, buzzer, motor_up, motor_down, gate_fault, state
    );

    modport slave (
        input  gate_open, limit_up, limit_down, obstruct,
        output lamp, buzzer, motor_up, motor_down, gate_fault, state
    );
endinterface

// File: rtl/lc_flash_gen.sv
// Warning-lamp flasher: lamp on for FLASH_HALF cycles, off for FLASH_HALF, starting with on.
// Held cleared (lamp dark, phase reset) whenever enable is low.
module lc_flash_gen #(
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic enable,
    output logic lamp
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FLASH_HALF - 1);

    logic             active_q;
    logic             phase_q;
    logic [CNT_W-1:0] cnt_q;

    // The first enabled edge only arms the flasher, so the lamp starts lit for a full half-period.
    always_ff @(posedge Clk) begin
        if (Reset || !enable) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (!active_q) begin
            active_q <= 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign lamp = active_q & ~phase_q;
endmodule

// File: rtl/level_crossing_gate_ctrl.sv
// Level-crossing gate sequencer: warning, boom lowering/raising with limit switches,
// obstruction pause, motor timeouts and a sticky fault state. Outputs decode registers only.
module level_crossing_gate_ctrl
    import lc_pkg::*;
#(
    parameter int WARN_CYCLES   = 20,
    parameter int MOTOR_TIMEOUT = 50,
    parameter int FLASH_HALF    = 4,
    parameter int CLEAR_HOLD    = 8,
    parameter int CNT_W         = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    level_crossing_gate_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WARN_N  = CNT_W'(WARN_CYCLES);
    localparam logic [CNT_W-1:0] TMO_N   = CNT_W'(MOTOR_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(CLEAR_HOLD);

    logic [LC_STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  obstruct_q;
    logic                  motor_down_act;
    logic                  limits_conflict;
    logic                  lamp_w;

    // One counter serves warn, motor-timeout and clear-hold; it saturates instead of wrapping.
    assign cnt_inc         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign motor_down_act  = (state_q == LC_LOWERING) && !obstruct_q;
    assign limits_conflict = bus.limit_up && bus.limit_down;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LC_OPEN: begin
                if (!bus.gate_open)
                    state_d = LC_WARN;
                else if (!bus.limit_up)
                    state_d = LC_RAISING;
            end
            LC_WARN: begin
                if (bus.gate_open)
                    state_d = LC_OPEN;
                else if (cnt_inc >= WARN_N)
                    state_d = LC_LOWERING;
                else
                    cnt_d = cnt_inc;
            end
            LC_LOWERING: begin
                // Time only counts while the motor is actually driven, so an obstruction pause never faults.
                if (motor_down_act && (cnt_inc >= TMO_N))
                    state_d = LC_FAULT;
                else if (bus.limit_down)
                    state_d = LC_CLOSED;
                else if (motor_down_act)
                    cnt_d = cnt_inc;
            end
            LC_CLOSED: begin
                if (!bus.gate_open)
                    cnt_d = '0;
                else if (cnt_inc >= HOLD_N)
                    state_d = LC_RAISING;
                else
                    cnt_d = cnt_inc;
            end
            LC_RAISING: begin
                if (cnt_inc >= TMO_N)
                    state_d = LC_FAULT;
                else if (!bus.gate_open)
                    state_d = LC_LOWERING;
                else if (bus.limit_up)
                    state_d = LC_OPEN;
                else
                    cnt_d = cnt_inc;
            end
            LC_FAULT: state_d = LC_FAULT;
            default:  state_d = LC_FAULT;
        endcase
        if (limits_conflict && (state_q != LC_FAULT))
            state_d = LC_FAULT;
        if (state_d != state_q)
            cnt_d = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= LC_OPEN;
            cnt_q      <= '0;
            obstruct_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            obstruct_q <= bus.obstruct;
        end
    end

    // Enabled from the next state so the lamp is already lit in the first cycle after leaving OPEN.
    lc_flash_gen #(
        .FLASH_HALF (FLASH_HALF),
        .CNT_W      (CNT_W)
    ) u_flash (
        .Clk    (Clk),
        .Reset  (Reset),
        .enable (state_d != LC_OPEN),
        .lamp   (lamp_w)
    );

    assign bus.state      = state_q;
    assign bus.lamp       = lamp_w;
    assign bus.buzzer     = (state_q == LC_WARN) || (state_q == LC_LOWERING);
    assign bus.motor_up   = (state_q == LC_RAISING);
    assign bus.motor_down = motor_down_act;
    assign bus.gate_fault = (state_q == LC_FAULT);
endmodule

// File: tb/tb_level_crossing_gate_ctrl.sv
// Directed bench for level_crossing_gate_ctrl with default parameters
// (WARN 20, MOTOR_TIMEOUT 50, FLASH_HALF 4, CLEAR_HOLD 8).
module tb_level_crossing_gate_ctrl;
    import lc_pkg::*;

    logic Clk;
    logic Reset;
    int   vec_cnt;
    int   err_cnt;

    level_crossing_gate_ctrl_if lc_bus ();

    level_crossing_gate_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (lc_bus)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        chk("motor_excl", {7'b0, lc_bus.motor_up & lc_bus.motor_down}, 8'h00);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st,
                              input logic bz, input logic mu, input logic md, input logic gf);
        chk(tag, {1'b0, lc_bus.state, lc_bus.buzzer, lc_bus.motor_up, lc_bus.motor_down, lc_bus.gate_fault},
                 {1'b0, st, bz, mu, md, gf});
    endtask

    task automatic expect_lamp(input string tag, input logic l);
        chk(tag, {7'b0, lc_bus.lamp}, {7'b0, l});
    endtask

    task automatic reset_pulse();
        Reset = 1'b1;
        tick();
        expect_out("rst_held", LC_OPEN, 0, 0, 0, 0);
        expect_lamp("rst_held_lamp", 1'b0);
        Reset = 1'b0;
        expect_out("rst_release", LC_OPEN, 0, 0, 0, 0);
    endtask

    task automatic enter_lowering();
        lc_bus.gate_open = 1'b0;
        ticks(20);
        expect_out("warn_last", LC_WARN, 1, 0, 0, 0);
        tick();
        expect_out("lower_entry", LC_LOWERING, 1, 0, 1, 0);
        lc_bus.limit_up = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        Reset             = 1'b1;
        lc_bus.gate_open  = 1'b1;
        lc_bus.limit_up   = 1'b1;
        lc_bus.limit_down = 1'b0;
        lc_bus.obstruct   = 1'b0;
        ticks(3);
        expect_out("reset", LC_OPEN, 0, 0, 0, 0);
        expect_lamp("reset_lamp", 1'b0);
        Reset = 1'b0;
        expect_out("post_release", LC_OPEN, 0, 0, 0, 0);
        tick();
        expect_out("open_idle", LC_OPEN, 0, 0, 0, 0);

        // Normal close: 20 WARN cycles, lamp on 4 / off 4 from the first WARN cycle.
        lc_bus.gate_open = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            expect_out("warn", LC_WARN, 1, 0, 0, 0);
            expect_lamp("warn_lamp", ((((c - 1) / 4) % 2) == 0));
        end
        tick();
        expect_out("lowering", LC_LOWERING, 1, 0, 1, 0);
        expect_lamp("lower_lamp", 1'b0);
        lc_bus.limit_up = 1'b0;
        for (int c = 22; c <= 30; c++) begin
            tick();
            expect_out("lowering_run", LC_LOWERING, 1, 0, 1, 0);
        end
        lc_bus.limit_down = 1'b1;
        for (int c = 31; c <= 38; c++) begin
            tick();
            expect_out("closed", LC_CLOSED, 0, 0, 0, 0);
            expect_lamp("closed_lamp", ((((c - 1) / 4) % 2) == 0));
        end

        // Reopen hysteresis: 7 high, 1 low, then 8 high.
        lc_bus.gate_open = 1'b1;
        ticks(7);
        expect_out("hold_7", LC_CLOSED, 0, 0, 0, 0);
        lc_bus.gate_open = 1'b0;
        tick();
        expect_out("hold_break", LC_CLOSED, 0, 0, 0, 0);
        lc_bus.gate_open = 1'b1;
        ticks(7);
        expect_out("hold_7b", LC_CLOSED, 0, 0, 0, 0);
        tick();
        expect_out("raising", LC_RAISING, 0, 1, 0, 0);
        lc_bus.limit_down = 1'b0;
        ticks(3);
        expect_out("raising_run", LC_RAISING, 0, 1, 0, 0);
        lc_bus.limit_up = 1'b1;
        tick();
        expect_out("reopened", LC_OPEN, 0, 0, 0, 0);
        expect_lamp("reopened_lamp", 1'b0);

        // WARN abort after 5 cycles.
        lc_bus.gate_open = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            expect_out("abort_warn", LC_WARN, 1, 0, 0, 0);
        end
        lc_bus.gate_open = 1'b1;
        tick();
        expect_out("abort_open", LC_OPEN, 0, 0, 0, 0);
        expect_lamp("abort_lamp", 1'b0);

        // Lowering timeout after exactly 50 motor-active cycles.
        enter_lowering();
        ticks(49);
        expect_out("pre_timeout", LC_LOWERING, 1, 0, 1, 0);
        tick();
        expect_out("timeout_fault", LC_FAULT, 0, 0, 0, 1);
        lc_bus.gate_open = 1'b1;
        lc_bus.limit_up  = 1'b1;
        ticks(4);
        expect_out("fault_sticky", LC_FAULT, 0, 0, 0, 1);
        reset_pulse();

        // Obstruction pauses the motor and the timeout.
        enter_lowering();
        ticks(5);
        lc_bus.obstruct = 1'b1;
        tick();
        expect_out("obstruct_pause", LC_LOWERING, 1, 0, 0, 0);
        for (int c = 0; c < 99; c++) begin
            tick();
            expect_out("obstruct_hold", LC_LOWERING, 1, 0, 0, 0);
        end
        lc_bus.obstruct = 1'b0;
        tick();
        expect_out("obstruct_resume", LC_LOWERING, 1, 0, 1, 0);
        ticks(3);
        lc_bus.limit_down = 1'b1;
        tick();
        expect_out("obstruct_closed", LC_CLOSED, 0, 0, 0, 0);

        // Reversal: dropping gate_open while raising restarts the lowering timeout.
        lc_bus.gate_open = 1'b1;
        ticks(8);
        expect_out("rev_raising", LC_RAISING, 0, 1, 0, 0);
        lc_bus.limit_down = 1'b0;
        ticks(10);
        lc_bus.gate_open = 1'b0;
        tick();
        expect_out("rev_lowering", LC_LOWERING, 1, 0, 1, 0);
        ticks(49);
        expect_out("rev_pre_timeout", LC_LOWERING, 1, 0, 1, 0);
        tick();
        expect_out("rev_timeout", LC_FAULT, 0, 0, 0, 1);
        lc_bus.gate_open = 1'b1;
        lc_bus.limit_up  = 1'b1;
        reset_pulse();

        // Sensor conflict in CLOSED.
        enter_lowering();
        ticks(2);
        lc_bus.limit_down = 1'b1;
        tick();
        expect_out("conf_closed", LC_CLOSED, 0, 0, 0, 0);
        lc_bus.limit_up = 1'b1;
        tick();
        expect_out("conf_fault", LC_FAULT, 0, 0, 0, 1);
        lc_bus.gate_open  = 1'b1;
        lc_bus.limit_down = 1'b0;
        reset_pulse();

        // Reset mid-lowering, then recovery of an unknown boom position.
        enter_lowering();
        ticks(3);
        reset_pulse();
        lc_bus.gate_open = 1'b1;
        tick();
        expect_out("recover_raise", LC_RAISING, 0, 1, 0, 0);
        expect_lamp("recover_lamp", 1'b1);
        lc_bus.limit_up = 1'b1;
        tick();
        expect_out("recover_open", LC_OPEN, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
